// File: rtl/logic_basic_queue_write_arbiter.sv
// Packet-aware round-robin arbiter merging INPUTS requester streams onto one
// registered stream feeding the queue write side.
module logic_basic_queue_write_arbiter #(
  parameter int INPUTS = 2,
  parameter int DATA_WIDTH = 1,
  localparam int GRANT_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic [INPUTS-1:0]            rx_tvalid,
  input  logic [INPUTS-1:0]            rx_tlast,
  input  logic [INPUTS*DATA_WIDTH-1:0] rx_tdata,
  output logic [INPUTS-1:0]            rx_tready,
  output logic                         tx_tvalid,
  output logic                         tx_tlast,
  output logic [DATA_WIDTH-1:0]        tx_tdata,
  input  logic                         tx_tready,
  output logic                         grant_valid,
  output logic [GRANT_WIDTH-1:0]       grant_index
);

  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  logic                   state;
  logic [GRANT_WIDTH-1:0] ptr;
  logic                   win_found;
  logic [GRANT_WIDTH-1:0] win_idx;
  logic                   out_ready;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   xfer;

  function automatic logic [GRANT_WIDTH-1:0] wrap_inc(input logic [GRANT_WIDTH-1:0] idx);
    if (int'(idx) >= INPUTS - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Search starts at the priority pointer and wraps, so candidates >= INPUTS never appear.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 0; k < INPUTS; k++) begin
      cand = int'(ptr) + k;
      if (cand >= INPUTS) cand = cand - INPUTS;
      if (!win_found && rx_tvalid[GRANT_WIDTH'(cand)]) begin
        win_found = 1'b1;
        win_idx   = GRANT_WIDTH'(cand);
      end
    end
  end

  assign out_ready = !tx_tvalid || tx_tready;

  always_comb begin
    rx_tready = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (grant_index == GRANT_WIDTH'(i)) begin
        rx_tready[i] = (state == LOCKED) && out_ready;
        sel_valid    = rx_tvalid[i];
        sel_last     = rx_tlast[i];
        sel_data     = rx_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer        = (state == LOCKED) && sel_valid && out_ready;
  assign grant_valid = (state == LOCKED);

  // Stage boundary: grant lock and the single output register.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state       <= IDLE;
      grant_index <= '0;
      ptr         <= '0;
      tx_tvalid   <= 1'b0;
      tx_tlast    <= 1'b0;
      tx_tdata    <= '0;
    end else begin
      if (state == IDLE) begin
        if (win_found) begin
          state       <= LOCKED;
          grant_index <= win_idx;
        end
      end else if (xfer && sel_last) begin
        state <= IDLE;
        ptr   <= wrap_inc(grant_index);
      end
      if (xfer) begin
        tx_tvalid <= 1'b1;
        tx_tdata  <= sel_data;
        tx_tlast  <= sel_last;
      end else if (tx_tready) begin
        tx_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_basic_queue_write_arbiter.sv
// Randomized bench for the packet-aware round-robin write arbiter with a
// packet-level reference model and an output scoreboard.
module tb_logic_basic_queue_write_arbiter;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int GW   = 2;
  localparam int PKTS = 40;

  logic            aclk = 1'b0;
  logic            areset_n;
  logic [N-1:0]    rx_tvalid;
  logic [N-1:0]    rx_tlast;
  logic [N*DW-1:0] rx_tdata;
  logic [N-1:0]    rx_tready;
  logic            tx_tvalid;
  logic            tx_tlast;
  logic [DW-1:0]   tx_tdata;
  logic            tx_tready;
  logic            grant_valid;
  logic [GW-1:0]   grant_index;

  logic_basic_queue_write_arbiter #(.INPUTS(N), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata), .rx_tready(rx_tready),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tdata(tx_tdata), .tx_tready(tx_tready),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  always #5 aclk = ~aclk;

  // Per-requester beat lists {last, data}, with a send cursor each.
  logic [DW:0] beats [N][$];
  int          cur [N];
  logic [DW:0] sb [$];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  bit m_locked, m_txv, m_just_rst;
  int m_owner, m_ptr, m_gi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (v[idx[GW-1:0]]) return idx;
    end
    return -1;
  endfunction

  initial begin : monitor
    logic [DW:0] exp_beat;
    forever begin
      @(negedge aclk);
      if (chk_en && tx_tvalid && tx_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_beat_unexpected actual=%0h required=none time=%0t",
                   {tx_tlast, tx_tdata}, $time);
        end else begin
          exp_beat = sb.pop_front();
          chk("tx_beat", {23'd0, tx_tlast, tx_tdata}, {23'd0, exp_beat});
        end
      end
    end
  end

  initial begin : main
    int          cyc, w, len, acc_owner;
    bit          n_locked, n_txv, acc, was_rst, done, all_sent;
    int          n_owner, n_ptr, n_gi;
    logic [DW:0] beat;
    logic [N-1:0] er, v, tl;
    logic [N*DW-1:0] td;

    for (int i = 0; i < N; i++) begin
      cur[i] = 0;
      for (int p = 0; p < PKTS; p++) begin
        len = 1 + int'($urandom_range(0, 3));
        for (int b = 0; b < len; b++)
          beats[i].push_back({(b == len - 1), 8'($urandom)});
      end
    end
    m_locked = 0; m_txv = 0; m_owner = 0; m_ptr = 0; m_gi = 0; m_just_rst = 0;
    areset_n = 1'b0; rx_tvalid = '0; rx_tlast = '0; rx_tdata = '0; tx_tready = 1'b0;
    cyc = 0; done = 0; acc_owner = 0; beat = '0;

    while (!done && cyc < 20000) begin
      @(negedge aclk);
      if (chk_en) begin
        er = '0;
        if (m_locked && (!m_txv || tx_tready)) er[m_owner[GW-1:0]] = 1'b1;
        chk("grant_valid", {31'd0, grant_valid}, {31'd0, m_locked});
        chk("grant_index", {30'd0, grant_index}, m_gi);
        chk("rx_tready", {29'd0, rx_tready}, {29'd0, er});
        chk("tx_tvalid", {31'd0, tx_tvalid}, {31'd0, m_txv});
        if (m_just_rst) chk("tx_reset_data", {23'd0, tx_tlast, tx_tdata}, 32'd0);
      end

      n_locked = m_locked; n_owner = m_owner; n_ptr = m_ptr; n_gi = m_gi; n_txv = m_txv;
      acc = 0;
      was_rst = !areset_n;
      if (was_rst) begin
        n_locked = 0; n_gi = 0; n_ptr = 0; n_txv = 0;
      end else begin
        if (!m_locked) begin
          w = rr_pick(rx_tvalid, m_ptr);
          if (w >= 0) begin
            n_locked = 1; n_owner = w; n_gi = w;
          end
        end else if (rx_tvalid[m_owner[GW-1:0]] && (!m_txv || tx_tready)) begin
          acc = 1;
          acc_owner = m_owner;
          beat = beats[m_owner][cur[m_owner]];
          if (beat[DW]) begin
            n_locked = 0;
            n_ptr = (m_owner + 1) % N;
          end
        end
        n_txv = acc ? 1'b1 : (tx_tready ? 1'b0 : m_txv);
      end

      @(posedge aclk);
      #1;
      m_locked = n_locked; m_owner = n_owner; m_ptr = n_ptr; m_gi = n_gi; m_txv = n_txv;
      if (acc) begin
        sb.push_back(beat);
        cur[acc_owner]++;
      end
      if (was_rst) begin
        sb.delete();
        chk_en = 1'b1;
      end
      m_just_rst = was_rst;
      cyc++;

      // Opening phase: every requester always valid with a free sink; later random with a forced stall and a reset pulse.
      areset_n = !(cyc < 3 || cyc == 300);
      if (cyc < 150) tx_tready = 1'b1;
      else if (cyc >= 250 && cyc < 255) tx_tready = 1'b0;
      else tx_tready = ($urandom_range(0, 3) != 0);
      v = '0; tl = '0; td = '0;
      all_sent = 1;
      for (int i = 0; i < N; i++) begin
        if (cur[i] < beats[i].size()) begin
          all_sent = 0;
          v[i[GW-1:0]] = (cyc < 150) || ($urandom_range(0, 2) != 0);
        end
        if (v[i[GW-1:0]]) begin
          tl[i[GW-1:0]] = beats[i][cur[i]][DW];
          td = td | ((N*DW)'(beats[i][cur[i]][DW-1:0]) << (i * DW));
        end else begin
          tl[i[GW-1:0]] = 1'($urandom);
          td = td | ((N*DW)'(8'($urandom)) << (i * DW));
        end
      end
      rx_tvalid = v; rx_tlast = tl; rx_tdata = td;
      done = all_sent && (sb.size() == 0) && !m_txv && (cyc > 310);
    end

    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d cycles required=completion pending=%0d", cyc, sb.size());
    end
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_basic_queue_write_arbiter.md
Name: logic_basic_queue_write_arbiter

Overview:
- Shares one queue write-side stream port between INPUTS requester streams.
- Arbitration is round-robin and packet-aware: a grant is held from the first beat of a packet until its tlast beat transfers.
- Output is registered (one-stage pipeline) and drives the rx_* side of the queue write block.
- Sits directly upstream of the queue write logic; the queue's rx_tready provides backpressure on tx_tready.

Parameters:
- INPUTS, 2, number of requester streams (>= 2).
- DATA_WIDTH, 1, width of each requester's data beat.
- GRANT_WIDTH, (INPUTS > 1) ? $clog2(INPUTS) : 1, width of the grant index. Derived; not overridden.

Ports:
- aclk  input  1  clock.
- areset_n  input  1  reset; synchronous, active-low.
- rx_tvalid  input  INPUTS  per-requester beat valid.
- rx_tlast  input  INPUTS  per-requester last beat of packet.
- rx_tdata  input  INPUTS*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- rx_tready  output  INPUTS  per-requester ready.
- tx_tvalid  output  1  merged beat valid, to the queue write side.
- tx_tlast  output  1  merged last-beat flag.
- tx_tdata  output  DATA_WIDTH  merged data.
- tx_tready  input  1  ready from the queue write side.
- grant_valid  output  1  a requester currently holds the lock.
- grant_index  output  GRANT_WIDTH  index of the locked requester.

Behaviour:
- Single clock domain, aclk. areset_n is synchronous, active-low: all state updates on posedge aclk when areset_n=0.
- Reset values:
  - tx_tvalid=0, tx_tlast=0, tx_tdata=0.
  - grant_valid=0, grant_index=0, priority pointer=0, state=IDLE.
  - rx_tready=0 (it is combinational from registered state, so it is 0 from the first post-reset cycle).
- State machine, IDLE / LOCKED:
  - IDLE: search rx_tvalid starting at the priority pointer, ascending with wrap. The first asserted index is winner w.
  - If a winner exists: next cycle state=LOCKED, grant_index=w, grant_valid=1.
  - If no rx_tvalid is set: remain IDLE.
  - rx_tready is all-zero in IDLE, so no transfer happens in the arbitration cycle. This gives one bubble per packet.
  - LOCKED: rx_tready[grant_index] = (!tx_tvalid || tx_tready). All other rx_tready bits are 0.
  - A transfer occurs when rx_tvalid[g] && rx_tready[g] (g = grant_index).
  - On a transfer with rx_tlast[g]=1: next cycle state=IDLE, grant_valid=0, priority pointer = (g+1) mod INPUTS. grant_index keeps its value.
- Output register:
  - On an accepted transfer, load tx_tdata/tx_tlast from requester g and set tx_tvalid=1.
  - Otherwise, if tx_tready=1, clear tx_tvalid to 0. tx_tdata/tx_tlast hold.
  - Accept and drain may occur in the same cycle, giving full throughput: one beat per cycle within a packet.
  - tx_tdata/tx_tlast are stable while tx_tvalid && !tx_tready.
- Latency: a requester's beat appears on tx_* one cycle after its transfer. The first beat of a packet appears no earlier than 2 cycles after rx_tvalid rises in IDLE.
- Fairness: the winner of each packet becomes lowest priority for the next arbitration. With all requesters continuously valid, grants rotate 0,1,...,INPUTS-1,0.
- Boundary conditions:
  - Single-beat packet (tlast on the first beat): lock lasts exactly 1 transfer, then IDLE.
  - Locked requester deasserts rx_tvalid mid-packet: lock is held and other requesters are blocked until the locked requester's tlast transfers.
  - Backpressure: while tx_tvalid=1 and tx_tready=0, no requester is ready and no beat is lost or duplicated.
  - Priority pointer wrap: when the pointer is INPUTS-1, the search order is INPUTS-1, 0, 1, ...
  - Non-power-of-two INPUTS: indices >= INPUTS are never granted, and pointer increments wrap to 0.
  - Reset asserted mid-packet: the lock is dropped and the output register is cleared. Any remaining beats of that packet are arbitrated as a new packet after reset.
  - rx_tlast/rx_tdata of non-granted requesters are ignored.

Test Plan:
- INPUTS=2, DATA_WIDTH=8. Requester 0 sends 3-beat packet A0,A1,A2 (tlast on A2), tx_tready=1 -> tx_tdata A0,A1,A2 on consecutive cycles; first beat 2 cycles after rx_tvalid; tx_tlast=1 only with A2.
- INPUTS=3. All three continuously valid with 1-beat packets, tx_tready=1 -> grant_index sequence 0,1,2,0,1,2; each output beat separated by one idle (bubble) cycle.
- Requester 1 locked mid-packet, requester 0 valid throughout, requester 1 drops tvalid for 4 cycles -> no requester-0 beats appear until requester 1's tlast beat is output; the next grant is 0.
- tx_tready held 0 for 5 cycles with tx_tvalid=1 -> tx_tdata stable, all rx_tready=0; on release, exactly one beat per cycle resumes with no loss or duplication.
- INPUTS=3, pointer=2 after serving requester 1, requesters 0 and 2 valid -> requester 2 wins, then requester 0.
- areset_n=0 for 1 cycle during beat 2 of a 4-beat packet -> next cycle tx_tvalid=0, grant_valid=0, rx_tready=0; after release, re-arbitration starts from requester 0.
